// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start bit, eight data bits LSB first, parity bit, stop bit.
// Parity inversion is selected by PARITY_ODD in the same way the gate library uses bubble masks.
module parity_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       serialOut,
  output logic       busy,
  output logic       txDone
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] LastTick = 8'(CLKS_PER_BIT - 1);

  state_t     r_state, w_nextState;
  logic [7:0] r_timer, w_nextTimer;
  logic [2:0] r_index, w_nextIndex;
  logic [7:0] r_shift, w_nextShift;
  logic       r_parity, w_nextParity;
  logic       r_serial, w_nextSerial;
  logic       r_done, w_nextDone;
  logic       w_bitEnd;
  logic       w_accept;

  assign w_bitEnd  = (r_timer == LastTick);
  assign txReady   = (r_state == IDLE) && !reset;
  assign w_accept  = txValid && txReady;
  assign serialOut = r_serial;
  assign txDone    = r_done;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_index  <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_serial <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_timer  <= w_nextTimer;
      r_index  <= w_nextIndex;
      r_shift  <= w_nextShift;
      r_parity <= w_nextParity;
      r_serial <= w_nextSerial;
      r_done   <= w_nextDone;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextTimer  = w_bitEnd ? 8'd0 : r_timer + 8'd1;
    w_nextIndex  = r_index;
    w_nextShift  = r_shift;
    w_nextParity = r_parity;
    w_nextDone   = 1'b0;

    case (r_state)
      IDLE: begin
        w_nextTimer = 8'd0;
        if (w_accept) begin
          w_nextShift  = txData;
          w_nextParity = PARITY_ODD ? ~^txData : ^txData;
          w_nextIndex  = 3'd0;
          w_nextState  = START;
        end
      end
      START: begin
        if (w_bitEnd) w_nextState = DATA;
      end
      DATA: begin
        if (w_bitEnd) begin
          if (r_index == 3'd7) begin
            w_nextState = PARITY;
          end else begin
            w_nextShift = r_shift >> 1;
            w_nextIndex = r_index + 3'd1;
          end
        end
      end
      PARITY: begin
        if (w_bitEnd) w_nextState = STOP;
      end
      STOP: begin
        if (w_bitEnd) begin
          w_nextState = IDLE;
          w_nextDone  = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase

    // The line level is registered, so it is derived from the state being entered.
    case (w_nextState)
      START:   w_nextSerial = 1'b0;
      DATA:    w_nextSerial = w_nextShift[0];
      PARITY:  w_nextSerial = w_nextParity;
      default: w_nextSerial = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Self-checking bench for parity_serial_tx: four instances cover even/odd parity and
// bit periods of 4, 2 and 1 clocks against a frame model built from the bit rules.
module tb_parity_serial_tx;

  logic       clock;
  logic       reset;
  logic [7:0] txData[4];
  logic       txValid[4];
  logic       txReady[4];
  logic       serialOut[4];
  logic       busy[4];
  logic       txDone[4];

  int checks = 0;
  int fails  = 0;

  parity_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) dutEven4 (
    .clock(clock), .reset(reset), .txData(txData[0]), .txValid(txValid[0]),
    .txReady(txReady[0]), .serialOut(serialOut[0]), .busy(busy[0]), .txDone(txDone[0]));
  parity_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) dutOdd4 (
    .clock(clock), .reset(reset), .txData(txData[1]), .txValid(txValid[1]),
    .txReady(txReady[1]), .serialOut(serialOut[1]), .busy(busy[1]), .txDone(txDone[1]));
  parity_serial_tx #(.CLKS_PER_BIT(2), .PARITY_ODD(0)) dutEven2 (
    .clock(clock), .reset(reset), .txData(txData[2]), .txValid(txValid[2]),
    .txReady(txReady[2]), .serialOut(serialOut[2]), .busy(busy[2]), .txDone(txDone[2]));
  parity_serial_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(0)) dutEven1 (
    .clock(clock), .reset(reset), .txData(txData[3]), .txValid(txValid[3]),
    .txReady(txReady[3]), .serialOut(serialOut[3]), .busy(busy[3]), .txDone(txDone[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int cpbOf(input int u);
    case (u)
      0, 1:    return 4;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit oddOf(input int u);
    return (u == 1);
  endfunction

  // Frame slot idx: 0 start, 1..8 data LSB first, 9 parity, 10 stop.
  function automatic logic expBit(input logic [7:0] d, input bit odd, input int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return logic'((ones % 2) != 0) ^ logic'(odd);
    end
    return 1'b1;
  endfunction

  // Presents a byte at a falling edge; returns at the falling edge just after the accept edge.
  task automatic sendByte(input int u, input logic [7:0] d);
    txData[u]  = d;
    txValid[u] = 1'b1;
    checks++;
    if (txReady[u] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_before_accept u%0d: got %b expected 1", u, txReady[u]);
    end
    @(negedge clock);
    txValid[u] = 1'b0;
  endtask

  // Walks one whole frame from cycle 0 and ends in the txDone cycle.
  task automatic walkFrame(input int u, input logic [7:0] d, input bit changeData,
                           input bit midValid);
    int c;
    logic e;
    c = cpbOf(u);
    for (int t = 0; t < 11 * c; t++) begin
      e = expBit(d, oddOf(u), t / c);
      checks++;
      if (serialOut[u] !== e) begin
        fails++;
        $display("[TB] FAIL serial u%0d d=%h cycle %0d: got %b expected %b", u, d, t, serialOut[u], e);
      end
      checks++;
      if (busy[u] !== 1'b1 || txDone[u] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL busy_done u%0d cycle %0d: got busy=%b done=%b expected busy=1 done=0",
                 u, t, busy[u], txDone[u]);
      end
      if (changeData && t == 2) txData[u] = 8'h00;
      if (midValid && t == 3 * c) begin
        txValid[u] = 1'b1;
        checks++;
        if (txReady[u] !== 1'b0) begin
          fails++;
          $display("[TB] FAIL ready_mid_frame u%0d: got %b expected 0", u, txReady[u]);
        end
      end
      if (midValid && t == 3 * c + 1) txValid[u] = 1'b0;
      @(negedge clock);
    end
    checks++;
    if (txDone[u] !== 1'b1 || busy[u] !== 1'b0 || txReady[u] !== 1'b1 || serialOut[u] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL frame_end u%0d: got done=%b busy=%b ready=%b serial=%b expected 1,0,1,1",
               u, txDone[u], busy[u], txReady[u], serialOut[u]);
    end
  endtask

  task automatic checkDoneCleared(input int u);
    checks++;
    if (txDone[u] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL done_one_cycle u%0d: got %b expected 0", u, txDone[u]);
    end
  endtask

  task automatic test_reset;
    #2;
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (serialOut[u] !== 1'b1 || txReady[u] !== 1'b0 || busy[u] !== 1'b0 || txDone[u] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_values u%0d: got serial=%b ready=%b busy=%b done=%b expected 1,0,0,0",
                 u, serialOut[u], txReady[u], busy[u], txDone[u]);
      end
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (txReady[u] !== 1'b1) begin
        fails++;
        $display("[TB] FAIL ready_after_reset u%0d: got %b expected 1", u, txReady[u]);
      end
    end
  endtask

  task automatic test_even_a5;
    sendByte(0, 8'hA5);
    walkFrame(0, 8'hA5, 1'b0, 1'b0);
    @(negedge clock);
    checkDoneCleared(0);
  endtask

  task automatic test_parity;
    sendByte(0, 8'h07);
    walkFrame(0, 8'h07, 1'b0, 1'b0);
    @(negedge clock);
    sendByte(1, 8'h07);
    walkFrame(1, 8'h07, 1'b0, 1'b0);
    @(negedge clock);
    checkDoneCleared(1);
  endtask

  task automatic test_back_to_back;
    txData[2]  = 8'h3C;
    txValid[2] = 1'b1;
    @(negedge clock);
    txData[2] = 8'hFF;
    walkFrame(2, 8'h3C, 1'b0, 1'b0);
    @(negedge clock);
    txValid[2] = 1'b0;
    walkFrame(2, 8'hFF, 1'b0, 1'b0);
    @(negedge clock);
    checkDoneCleared(2);
  endtask

  task automatic test_data_hold;
    sendByte(0, 8'h81);
    walkFrame(0, 8'h81, 1'b1, 1'b1);
    @(negedge clock);
    checkDoneCleared(0);
  endtask

  task automatic test_reset_midframe;
    sendByte(0, 8'hF0);
    repeat (17) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (serialOut[0] !== 1'b1 || busy[0] !== 1'b0 || txReady[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: got serial=%b busy=%b ready=%b expected 1,0,0",
               serialOut[0], busy[0], txReady[0]);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      checks++;
      if (txDone[0] !== 1'b0 || serialOut[0] !== 1'b1 || busy[0] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL aborted_frame cycle %0d: got done=%b serial=%b busy=%b expected 0,1,0",
                 t, txDone[0], serialOut[0], busy[0]);
      end
    end
    sendByte(0, 8'h55);
    walkFrame(0, 8'h55, 1'b0, 1'b0);
    @(negedge clock);
  endtask

  task automatic test_c1;
    sendByte(3, 8'h01);
    walkFrame(3, 8'h01, 1'b0, 1'b0);
    @(negedge clock);
    checkDoneCleared(3);
  endtask

  task automatic test_random;
    int u;
    logic [7:0] d;
    for (int n = 0; n < 12; n++) begin
      u = int'($urandom_range(0, 3));
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      sendByte(u, d);
      walkFrame(u, d, 1'b0, 1'b0);
      @(negedge clock);
      checkDoneCleared(u);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 4; u++) begin
      txData[u]  = 8'h00;
      txValid[u] = 1'b0;
    end
    test_reset;
    test_even_a5;
    test_parity;
    test_back_to_back;
    test_data_hold;
    test_reset_midframe;
    test_c1;
    test_random;
    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/parity_serial_tx.md
# parity_serial_tx

Serial frame transmitter producing one start bit, eight data bits LSB first, one parity bit and one stop bit from a parallel byte. Parity is computed with the same XOR/XNOR convention as the gate library; the inversion is controlled by a parameter, in the same way the gates use bubble masks. The block sits on the transmit side of the serial link and is the transmit end that the parity-checking receive path validates.

## Interface
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range 1..255; internal bit-timer is 8 bits.
- PARITY_ODD, 0: 0 = even parity (parity bit = XOR of data); 1 = odd parity (XNOR, inverted).
- clock  input  1  single system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- txData  input  8  byte to send; sampled only on accept.
- txValid  input  1  request to send txData.
- txReady  output  1  block can accept a byte this cycle.
- serialOut  output  1  serial line; idle level 1.
- busy  output  1  frame in progress (any state except IDLE).
- txDone  output  1  one-cycle pulse after the stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: serialOut=1, txReady=1. Accept occurs when txValid=1 and txReady=1 at a rising edge. On accept:
  - latch txData into the shift register;
  - compute the parity bit (^txData, or ~^txData if PARITY_ODD=1) and latch it;
  - go to START and clear the bit timer and bit index.
- START: serialOut=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: serialOut=shift[0]. After each CLKS_PER_BIT cycles, shift right and increment the bit index 0..7. After bit 7 completes, go to PARITY.
- PARITY: serialOut=parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: serialOut=1 for CLKS_PER_BIT cycles, then go to IDLE with txDone registered high.
- txReady = (state==IDLE) and not reset. txValid without txReady is ignored; no queuing.
- txData changes after accept have no effect on the current frame.
- busy = (state!=IDLE).
- serialOut and txDone are registered outputs, so there is no combinational path from the inputs to serialOut.
- Reset, asynchronous and possibly mid-frame:
  - state=IDLE, serialOut=1, txDone=0, busy=0, timer/index/shift/parity=0;
  - txReady=0 while reset is high and 1 from the first edge after release;
  - the aborted frame is never completed and txDone is not pulsed.

## Timing
- Reset values: serialOut=1, txReady=0 (during reset), busy=0, txDone=0.
- Accept at edge N; the start bit appears on serialOut from edge N (registered update at that edge).
- Frame length is exactly 11*CLKS_PER_BIT cycles:
  - start bit: cycles 0..C-1;
  - data bit k: cycles C*(k+1)..C*(k+2)-1;
  - parity bit: cycles 9C..10C-1;
  - stop bit: cycles 10C..11C-1.
- At edge N+11C the state returns to IDLE. In that cycle txDone=1 and txReady=1, and busy falls.
- Back-to-back: if txValid=1 in the txDone cycle, the next start bit begins at edge N+11C+1. The minimum stop level is therefore C+1 cycles and there is no extra idle bit.
- txDone lasts exactly one cycle and is cleared on the next edge regardless of txValid.
- CLKS_PER_BIT=1: each bit lasts one cycle and the frame is 11 cycles. No other special case applies.

## Test plan
- Even, C=4, send 0xA5: serialOut is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, parity 0, stop 1. txDone pulses at accept+44 and busy is high for 44 cycles.
- Even, C=4, send 0x07: parity bit 1. With PARITY_ODD=1 the same byte gives parity bit 0.
- Back-to-back, C=2, txValid held high with 0x3C then 0xFF: the second start bit begins one cycle after txDone. The frames are 22 cycles each, and the second frame's parity is 0 in even mode.
- txData is changed to 0x00 two cycles after accepting 0x81: the transmitted data is still 1,0,0,0,0,0,0,1. txValid asserted mid-frame is ignored (txReady=0).
- Reset is asserted during DATA bit 3 of 0xF0: serialOut=1 immediately without waiting for an edge, and busy=0. txDone never pulses for the aborted frame. After release, a new frame 0x55 transmits correctly.
- C=1, send 0x01: the frame is 0,1,0,0,0,0,0,0,0,1,1 across 11 cycles (even parity 1). txDone asserts at accept+11.
